uart_frame_ctrl: RTL and testbench
==================================

Name: uart_frame_ctrl

Overview:
Sequencing controller behind the UART byte receiver. It consumes the receiver's one-cycle `take` strobe and 8-bit data, and finds frames of the form SYNC, LEN, LEN payload bytes, CHECKSUM. Payload bytes are written into a downstream buffer, and the block pulses done or error per frame. It is the single owner of received-byte sequencing between the receiver and the command/register logic.

Parameters:
SYNC_BYTE, 8'hA5, start-of-frame marker.
MAX_LEN, 16, largest legal payload length (1..255).
ADDR_W, 4, buffer address width; ceil(log2(MAX_LEN)).
TIMEOUT_CYC, 16'h1B00, inter-byte timeout in clk cycles (used only with the optional feature).

Ports:
clk  in  1  system clock, all logic on posedge.
res  in  1  synchronous active-high reset.
take  in  1  one-cycle byte-valid strobe from the receiver.
din  in  8  received byte, valid when take=1.
wr_en  out  1  payload buffer write strobe.
wr_addr  out  ADDR_W  payload buffer write address.
wr_data  out  8  payload byte.
frame_len  out  8  length of the last good frame.
frame_done  out  1  one-cycle pulse: good frame complete.
frame_err  out  1  one-cycle pulse: frame aborted.
err_code  out  2  cause of the last error: 1 = bad LEN, 2 = checksum, 3 = timeout.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (res=1 at posedge):
  - state goes to IDLE.
  - wr_en, frame_done, frame_err, busy are 0; wr_addr, wr_data, frame_len, err_code are 0.
  - Internal byte counter and checksum are 0.
  - Reset mid-frame discards the partial frame silently: no done or err pulse.
- All outputs are registered. Every reaction to a take happens on the cycle after the posedge that samples take=1.
- States: IDLE, LEN, PAYLOAD, CSUM, DONE, ERR.
- IDLE:
  - take with din==SYNC_BYTE -> LEN.
  - Any other byte is ignored (resync hunting).
- LEN, on take:
  - din==0 or din>MAX_LEN -> ERR with err_code=1.
  - Otherwise latch len=din, sum=din, cnt=0 -> PAYLOAD.
- PAYLOAD, on take:
  - Register wr_en=1, wr_addr=cnt[ADDR_W-1:0], wr_data=din.
  - sum <= sum+din (8-bit, wraps mod 256); cnt <= cnt+1.
  - When cnt==len-1, go to CSUM.
  - wr_en is high exactly one cycle per payload byte.
- CSUM, on take:
  - din==sum -> DONE.
  - Otherwise -> ERR with err_code=2.
- DONE:
  - frame_done=1 for one cycle; frame_len<=len; -> IDLE.
  - frame_len holds until the next DONE.
- ERR:
  - frame_err=1 for one cycle; err_code holds until the next ERR; -> IDLE.
- A take arriving while in DONE or ERR is dropped; it is not treated as SYNC.
- A SYNC_BYTE value inside LEN, PAYLOAD or CSUM is ordinary data. There is no mid-frame resync.
- No take while in LEN, PAYLOAD or CSUM: the block waits indefinitely unless the timeout feature is compiled in.
- A payload already written before an error stays in the buffer. The consumer must only trust the buffer after frame_done.

Optional Feature:
Macro UART_FRAME_TIMEOUT_EN.
- Defined:
  - A 16-bit down-counter loads TIMEOUT_CYC on entry to LEN and on every take in LEN, PAYLOAD or CSUM.
  - It decrements each cycle in those states.
  - Reaching 0 with no take in the same cycle -> ERR with err_code=3.
  - A take in the same cycle as the counter reaching 0 wins; no timeout is raised.
- Not defined: no counter is built, and err_code never equals 3.

Decomposition:
- Package uart_frame_pkg holds:
  - the state encoding typedef (6 states);
  - error-code constants ERR_NONE=0, ERR_LEN=1, ERR_CSUM=2, ERR_TIMEOUT=3;
  - default SYNC_BYTE.
- One sub-module is natural: uart_frame_timeout (load/decrement/expire counter).
  - It is instantiated only under UART_FRAME_TIMEOUT_EN.
- The FSM, checksum and write logic stay in uart_frame_ctrl.

Test Plan:
1. Bytes A5 03 11 22 33 69 -> wr_en x3 at addr 0,1,2 with data 11,22,33; frame_done one cycle; frame_len=3; no frame_err.
2. Bytes 00 FF A5 01 7E 7F -> the leading 00 and FF are ignored; one write of 7E at addr 0; frame_done; frame_len=1.
3. Bytes A5 02 10 20 00 -> two writes; frame_err with err_code=2; no frame_done; then A5 01 05 06 -> frame_done.
4. Bytes A5 00, and separately A5 11 (MAX_LEN=16) -> frame_err with err_code=1 immediately after the LEN byte; no wr_en.
5. With UART_FRAME_TIMEOUT_EN: A5 02 10, then idle for TIMEOUT_CYC+2 cycles -> frame_err with err_code=3; busy drops. Without the macro, the same stimulus leaves busy=1 with no error.
6. res=1 for one cycle after A5 03 11 -> all outputs 0 and state IDLE; then A5 01 AA AB -> frame_done, write AA at addr 0.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame sequencer: state encoding, error codes, default SYNC marker.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte watchdog: loads on every accepted byte, counts down while a frame is open, flags expiry at zero.
// Expiry is combinational from the counter so the controller can let a same-cycle byte win.
module uart_frame_timeout #(
    parameter logic [15:0] TIMEOUT_CYC = 16'h1B00
) (
    input  logic clk,
    input  logic res,
    input  logic load,
    input  logic run,
    output logic expired
);

    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (res) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= TIMEOUT_CYC;
        end else if (run && (cnt_q != 16'd0)) begin
            cnt_q <= cnt_q - 16'd1;
        end
    end

    assign expired = run && (cnt_q == 16'd0);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame sequencer behind the UART receiver: SYNC, LEN, payload, checksum; writes payload and pulses done/err.
// Optional inter-byte timeout compiled in with UART_FRAME_TIMEOUT_EN; all outputs registered, one cycle after take.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    parameter int          MAX_LEN     = 16,
    parameter int          ADDR_W      = 4,
    parameter logic [15:0] TIMEOUT_CYC = 16'h1B00
) (
    input  logic              clk,
    input  logic              res,
    input  logic              take,
    input  logic [7:0]        din,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [7:0]        frame_len,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t            state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              wr_en_d, frame_done_d, frame_err_d, busy_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [7:0]        wr_data_d, frame_len_d;
    logic [1:0]        err_code_d;
    logic              in_frame;
    logic              tmo_expired;

    assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);

`ifdef UART_FRAME_TIMEOUT_EN
    logic tmo_load;

    // Reload on the SYNC that opens a frame and on every byte inside it.
    assign tmo_load = take && (in_frame || ((state_q == ST_IDLE) && (din == SYNC_BYTE)));

    uart_frame_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .res     (res),
        .load    (tmo_load),
        .run     (in_frame),
        .expired (tmo_expired)
    );
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign tmo_expired        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        sum_d        = sum_q;
        cnt_d        = cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr;
        wr_data_d    = wr_data;
        frame_len_d  = frame_len;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = err_code;

        unique case (state_q)
            ST_IDLE: begin
                if (take && (din == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (take) begin
                    if ((din == 8'd0) || (din > MAX_LEN_B)) begin
                        state_d     = ST_ERR;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                    end else begin
                        state_d = ST_PAYLOAD;
                        len_d   = din;
                        sum_d   = din;
                        cnt_d   = 8'd0;
                    end
                end else if (tmo_expired) begin
                    state_d     = ST_ERR;
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                end
            end
            ST_PAYLOAD: begin
                if (take) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[ADDR_W-1:0];
                    wr_data_d = din;
                    sum_d     = sum_q + din;
                    cnt_d     = cnt_q + 8'd1;
                    if (cnt_q == (len_q - 8'd1)) begin
                        state_d = ST_CSUM;
                    end
                end else if (tmo_expired) begin
                    state_d     = ST_ERR;
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                end
            end
            ST_CSUM: begin
                if (take) begin
                    if (din == sum_q) begin
                        state_d      = ST_DONE;
                        frame_done_d = 1'b1;
                        frame_len_d  = len_q;
                    end else begin
                        state_d     = ST_ERR;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                    end
                end else if (tmo_expired) begin
                    state_d     = ST_ERR;
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                end
            end
            // Pulse cycle: any byte arriving here is dropped, never taken as SYNC.
            ST_DONE, ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_len  <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= ERR_NONE;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            frame_len  <= frame_len_d;
            frame_done <= frame_done_d;
            frame_err  <= frame_err_d;
            err_code   <= err_code_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl: directed byte streams push expected writes/pulses, a monitor pops and compares.
module tb_uart_frame_ctrl;

    localparam logic [15:0] TIMEOUT_CYC = 16'h1B00;
    localparam logic [1:0]  K_WR = 2'd0, K_DONE = 2'd1, K_ERR = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       take = 1'b0;
    logic [7:0] din = 8'h00;
    logic       wr_en, frame_done, frame_err, busy;
    logic [3:0] wr_addr;
    logic [7:0] wr_data, frame_len;
    logic [1:0] err_code;

    ev_t exp_q[$];
    ev_t got, want;
    int  n_vec  = 0;
    int  n_miss = 0;

    uart_frame_ctrl dut (
        .clk        (clk),
        .res        (res),
        .take       (take),
        .din        (din),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_len  (frame_len),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1, "global timeout");
    end

    always @(negedge clk) begin
        if (!res && (wr_en || frame_done || frame_err)) begin
            got.kind = wr_en ? K_WR : (frame_done ? K_DONE : K_ERR);
            got.addr = wr_en ? wr_addr : 4'd0;
            got.data = wr_en ? wr_data : (frame_done ? frame_len : {6'd0, err_code});
            n_vec++;
            if ((32'(wr_en) + 32'(frame_done) + 32'(frame_err)) > 1) begin
                n_miss++;
                $display("FAIL overlap wr_en=%0b done=%0b err=%0b at %0t", wr_en, frame_done, frame_err, $time);
            end else if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_event got kind=%0d addr=%0d data=%02h, none expected at %0t",
                         got.kind, got.addr, got.data, $time);
            end else begin
                want = exp_q.pop_front();
                if (got != want) begin
                    n_miss++;
                    $display("FAIL event got kind=%0d addr=%0d data=%02h, expected kind=%0d addr=%0d data=%02h at %0t",
                             got.kind, got.addr, got.data, want.kind, want.addr, want.data, $time);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_wr(input logic [3:0] a, input logic [7:0] d);
        exp_q.push_back('{kind: K_WR, addr: a, data: d});
    endtask

    task automatic exp_done(input logic [7:0] l);
        exp_q.push_back('{kind: K_DONE, addr: 4'd0, data: l});
    endtask

    task automatic exp_err(input logic [1:0] c);
        exp_q.push_back('{kind: K_ERR, addr: 4'd0, data: {6'd0, c}});
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        take = 1'b1;
        din  = b;
        @(negedge clk);
        take = 1'b0;
    endtask

    task automatic send2(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        take = 1'b1;
        din  = a;
        @(negedge clk);
        din  = b;
        @(negedge clk);
        take = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_en"},     32'(wr_en),      32'd0);
        check({tag, "_done"},      32'(frame_done), 32'd0);
        check({tag, "_err"},       32'(frame_err),  32'd0);
        check({tag, "_busy"},      32'(busy),       32'd0);
        check({tag, "_wr_addr"},   32'(wr_addr),    32'd0);
        check({tag, "_wr_data"},   32'(wr_data),    32'd0);
        check({tag, "_frame_len"}, 32'(frame_len),  32'd0);
        check({tag, "_err_code"},  32'(err_code),   32'd0);
    endtask

    initial begin
        idle(3);
        res = 1'b0;
        @(negedge clk);
        check_zero("reset");

        // Test 1: three-byte frame
        exp_wr(4'd0, 8'h11); exp_wr(4'd1, 8'h22); exp_wr(4'd2, 8'h33); exp_done(8'd3);
        send(8'hA5);
        check("busy_after_sync", 32'(busy), 32'd1);
        send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
        idle(2);
        check("t1_frame_len", 32'(frame_len), 32'd3);
        check("t1_busy_idle", 32'(busy), 32'd0);

        // Test 2: leading garbage ignored
        exp_wr(4'd0, 8'h7E); exp_done(8'd1);
        send(8'h00); send(8'hFF);
        check("t2_hunting_busy", 32'(busy), 32'd0);
        send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
        idle(2);

        // Test 3: bad checksum, then good frame
        exp_wr(4'd0, 8'h10); exp_wr(4'd1, 8'h20); exp_err(2'd2);
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
        idle(2);
        check("t3_len_held_after_err", 32'(frame_len), 32'd1);
        exp_wr(4'd0, 8'h05); exp_done(8'd1);
        send(8'hA5); send(8'h01); send(8'h05); send(8'h06);
        idle(2);
        check("t3_code_held_after_done", 32'(err_code), 32'd2);

        // SYNC value inside payload is data; checksum wraps: 02+A5+A5 = 14C -> 4C
        exp_wr(4'd0, 8'hA5); exp_wr(4'd1, 8'hA5); exp_done(8'd2);
        send(8'hA5); send(8'h02); send(8'hA5); send(8'hA5); send(8'h4C);
        idle(2);

        // A5 arriving during the DONE cycle must be dropped; 01 02 03 then stay ignored
        exp_wr(4'd0, 8'h05); exp_done(8'd1);
        send(8'hA5); send(8'h01); send(8'h05);
        send2(8'h06, 8'hA5);
        send(8'h01); send(8'h02); send(8'h03);
        idle(2);
        check("drop_in_done_busy", 32'(busy), 32'd0);

        // Test 4: illegal lengths
        exp_err(2'd1);
        send(8'hA5); send(8'h00);
        idle(2);
        exp_err(2'd1);
        send(8'hA5); send(8'h11);
        idle(2);
        check("t4_err_code", 32'(err_code), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);

        // Test 5: stalled frame
        exp_wr(4'd0, 8'h10);
`ifdef UART_FRAME_TIMEOUT_EN
        exp_err(2'd3);
`endif
        send(8'hA5); send(8'h02); send(8'h10);
        idle(int'(TIMEOUT_CYC) + 4);
`ifdef UART_FRAME_TIMEOUT_EN
        check("t5_busy_after_timeout", 32'(busy), 32'd0);
        check("t5_err_code", 32'(err_code), 32'd3);
`else
        check("t5_busy_stalled", 32'(busy), 32'd1);
        check("t5_err_code_held", 32'(err_code), 32'd1);
`endif
        pulse_reset();
        check_zero("t5_reset");

        // Test 6: reset mid-frame, then a clean frame
        exp_wr(4'd0, 8'h11);
        send(8'hA5); send(8'h03); send(8'h11);
        pulse_reset();
        check_zero("t6_reset");
        exp_wr(4'd0, 8'hAA); exp_done(8'd1);
        send(8'hA5); send(8'h01); send(8'hAA); send(8'hAB);
        idle(4);
        check("t6_frame_len", 32'(frame_len), 32'd1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
